// File: rtl/score_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : score_display_scan_if
// Brief    : Score input and seven-segment pin bundle for score_display_scan.
// Revision : 1.0 - initial release
// ============================================================================
interface score_display_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 32
);
  logic [SCORE_W-1:0]    score;
  logic                  blink_en;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [7:0]            segment;
  logic [NUM_DIGITS-1:0] AN;
  logic                  bcd_valid;
  logic                  overflow;

  modport master (
    output score, blink_en, dp_mask,
    input  segment, AN, bcd_valid, overflow
  );

  modport slave (
    input  score, blink_en, dp_mask,
    output segment, AN, bcd_valid, overflow
  );
endinterface
`default_nettype wire

// File: rtl/score_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : score_display_scan
// Brief    : Sequential double-dabble score converter and multiplexed
//            seven-segment scanner with blanking, saturation and blink.
// Revision : 1.0 - initial release
// ============================================================================
module score_display_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 32,
  parameter int CLK_HZ     = 100000000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2,
  parameter int BLANK_LZ   = 1
) (
  input wire logic            clk,
  input wire logic            rst,
  score_display_scan_if.slave bus
);

  localparam int c_SCAN_DIV  = (CLK_HZ / SCAN_HZ < 1) ? 1 : CLK_HZ / SCAN_HZ;
  localparam int c_BLINK_DIV = (CLK_HZ / (2 * BLINK_HZ) < 1) ? 1 : CLK_HZ / (2 * BLINK_HZ);
  localparam int c_SCAN_W    = ($clog2(c_SCAN_DIV) < 1) ? 1 : $clog2(c_SCAN_DIV);
  localparam int c_BLINK_W   = ($clog2(c_BLINK_DIV) < 1) ? 1 : $clog2(c_BLINK_DIV);
  localparam int c_IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_CNT_W     = $clog2(SCORE_W + 1);

  localparam logic [c_SCAN_W-1:0]  c_SCAN_TC  = c_SCAN_W'(c_SCAN_DIV - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_TC = c_BLINK_W'(c_BLINK_DIV - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
  localparam logic [c_CNT_W-1:0]   c_BIT_LAST = c_CNT_W'(SCORE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic                            w_capture;
  logic                            w_shift;
  logic                            w_load;

  logic [SCORE_W-1:0]              r_sr;
  logic [SCORE_W-1:0]              r_last_score;
  logic [NUM_DIGITS-1:0][3:0]      r_work;
  logic [NUM_DIGITS-1:0][3:0]      w_adj;
  logic [NUM_DIGITS-1:0][3:0]      r_disp;
  logic [c_CNT_W-1:0]              r_bitcnt;
  logic                            r_ovf;
  logic                            r_overflow;
  logic                            r_bcd_valid;

  logic [c_SCAN_W-1:0]             r_pre;
  logic [c_IDX_W-1:0]              r_idx;
  logic [c_BLINK_W-1:0]            r_bcnt;
  logic                            r_phase;
  logic [NUM_DIGITS-1:0]           r_an;
  logic [7:0]                      r_seg;

  logic [NUM_DIGITS-1:0]           w_zero_from;
  logic [3:0]                      w_digit;
  logic                            w_blank;
  logic [6:0]                      w_seg7;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((bus.score != r_last_score) || !r_bcd_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_bitcnt == c_BIT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_load      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ double dabble
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_work[i] >= 4'd5) w_adj[i] = r_work[i] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr         <= '0;
      r_last_score <= '0;
      r_work       <= '0;
      r_disp       <= '0;
      r_bitcnt     <= '0;
      r_ovf        <= 1'b0;
      r_overflow   <= 1'b0;
      r_bcd_valid  <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sr         <= bus.score;
        r_last_score <= bus.score;
        r_work       <= '0;
        r_ovf        <= 1'b0;
        r_bitcnt     <= '0;
      end
      if (w_shift) begin
        // A carry out of the top digit means the score needs more digits.
        {r_work, r_sr} <= {w_adj, r_sr} << 1;
        r_ovf          <= r_ovf | w_adj[NUM_DIGITS-1][3];
        r_bitcnt       <= r_bitcnt + c_CNT_W'(1);
      end
      if (w_load) begin
        r_disp      <= r_ovf ? {NUM_DIGITS{4'h9}} : r_work;
        r_overflow  <= r_ovf;
        r_bcd_valid <= 1'b1;
      end
    end
  end

  // ------------------------------------------------- digit decode/blank
  always_comb begin
    w_zero_from                 = '0;
    w_zero_from[NUM_DIGITS-1]   = (r_disp[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_zero_from[i] = w_zero_from[i+1] && (r_disp[i] == 4'd0);
    end
  end

  always_comb begin
    w_digit = r_disp[r_idx];
    w_blank = (BLANK_LZ != 0) && (r_idx != '0) && w_zero_from[r_idx] && !r_overflow;
    case (w_digit)
      4'd0:    w_seg7 = 7'h40;
      4'd1:    w_seg7 = 7'h79;
      4'd2:    w_seg7 = 7'h24;
      4'd3:    w_seg7 = 7'h30;
      4'd4:    w_seg7 = 7'h19;
      4'd5:    w_seg7 = 7'h12;
      4'd6:    w_seg7 = 7'h02;
      4'd7:    w_seg7 = 7'h78;
      4'd8:    w_seg7 = 7'h00;
      4'd9:    w_seg7 = 7'h10;
      default: w_seg7 = 7'h7F;
    endcase
    if (w_blank) w_seg7 = 7'h7F;
  end

  // ------------------------------------------------- scan, blink, pins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b0;
      r_an    <= '1;
      r_seg   <= 8'hFF;
    end else begin
      if (r_pre == c_SCAN_TC) begin
        r_pre <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
      end else begin
        r_pre <= r_pre + c_SCAN_W'(1);
      end

      if (!bus.blink_en) begin
        r_bcnt  <= '0;
        r_phase <= 1'b0;
      end else if (r_bcnt == c_BLINK_TC) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + c_BLINK_W'(1);
      end

      if (!r_bcd_valid) begin
        r_an  <= '1;
        r_seg <= 8'hFF;
      end else begin
        r_an  <= r_phase ? '1 : ~(NUM_DIGITS'(1) << r_idx);
        r_seg <= {~bus.dp_mask[r_idx], w_seg7};
      end
    end
  end

  assign bus.segment   = r_seg;
  assign bus.AN        = r_an;
  assign bus.bcd_valid = r_bcd_valid;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_score_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display_scan
// Brief    : Self-checking bench: vector table, hand sequences, random scores.
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_display_scan;
  localparam int ND = 4;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_display_scan_if #(.NUM_DIGITS(ND), .SCORE_W(SW)) bus ();

  score_display_scan #(
    .NUM_DIGITS(ND), .SCORE_W(SW), .CLK_HZ(1000), .SCAN_HZ(250),
    .BLINK_HZ(50), .BLANK_LZ(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] enc [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [31:0]     score;
    logic [3:0]      dp;
    logic [3:0][7:0] seg;
    logic            ovf;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(input logic [31:0] s, input logic [3:0] dp,
                              input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0,
                              input logic ovf);
    vec_t v;
    v.score = s;
    v.dp    = dp;
    v.seg   = {s3, s2, s1, s0};
    v.ovf   = ovf;
    return v;
  endfunction

  // Decimal reference: digit i of the value, saturating at 9999.
  function automatic logic [7:0] model_seg(input logic [31:0] val, input logic [3:0] dp, input int i);
    longint unsigned p = 1;
    int unsigned d;
    logic [6:0] s;
    for (int k = 0; k < i; k++) p = p * 10;
    if (val >= 32'd10000) s = enc[9];
    else if (i != 0 && longint'(val) < p) s = 7'h7F;
    else begin
      d = int'((longint'(val) / p) % 10);
      s = enc[d];
    end
    return {~dp[i], s};
  endfunction

  function automatic logic [3:0][7:0] model_all(input logic [31:0] val, input logic [3:0] dp);
    logic [3:0][7:0] r;
    for (int i = 0; i < ND; i++) r[i] = model_seg(val, dp, i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_lit(input string tag, input logic [3:0][7:0] exp, output int idx);
    logic [3:0] m;
    idx = -1;
    for (int i = 0; i < ND; i++) begin
      m = 4'b1 << i;
      if (bus.AN == ~m) idx = i;
    end
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL %s_an: AN=%h is not a single active digit", tag, bus.AN);
    end else if (bus.segment !== exp[idx]) begin
      failures++;
      $display("FAIL %s_seg%0d: segment=%h expected %h", tag, idx, bus.segment, exp[idx]);
    end
  endtask

  task automatic chk_scan(input string tag, input logic [3:0][7:0] exp, input logic ovf);
    int idx;
    int prev  = -1;
    int run   = 0;
    bit first = 1'b1;
    logic [3:0] seen = '0;
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf));
    chk({tag, "_valid"}, 32'(bus.bcd_valid), 32'd1);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk_lit(tag, exp, idx);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        if (prev >= 0 && idx != prev) begin
          chk({tag, "_order"}, 32'(idx), 32'((prev + 1) % ND));
          if (!first) chk({tag, "_dwell"}, 32'(run), 32'd4);
          first = 1'b0;
          run   = 0;
        end
        prev = idx;
        run++;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'hF);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0][7:0] e5, e42, ecur;
    logic [31:0] cur_val;
    logic [3:0]  cur_dp;
    int idx;

    tbl[0] = mk(32'd1234,  4'b0000, 8'hF9, 8'hA4, 8'hB0, 8'h99, 1'b0);
    tbl[1] = mk(32'd7,     4'b0100, 8'hFF, 8'h7F, 8'hFF, 8'hF8, 1'b0);
    tbl[2] = mk(32'd10000, 4'b0000, 8'h90, 8'h90, 8'h90, 8'h90, 1'b1);
    tbl[3] = mk(32'd9999,  4'b0000, 8'h90, 8'h90, 8'h90, 8'h90, 1'b0);
    tbl[4] = mk(32'd0,     4'b0000, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 1'b0);
    tbl[5] = mk(32'd0,     4'b1111, 8'h7F, 8'h7F, 8'h7F, 8'h40, 1'b0);
    tbl[6] = mk(32'd1000,  4'b0001, 8'hF9, 8'hC0, 8'hC0, 8'h40, 1'b0);
    tbl[7] = mk(32'd50,    4'b0000, 8'hFF, 8'hFF, 8'h92, 8'hC0, 1'b0);
    tbl[8] = mk(32'd305,   4'b1000, 8'h7F, 8'hB0, 8'hC0, 8'h92, 1'b0);

    rst          = 1'b1;
    bus.score    = '0;
    bus.blink_en = 1'b0;
    bus.dp_mask  = '0;

    // Reset held three cycles, then first conversion latency
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_an", 32'(bus.AN), 32'hF);
      chk("rst_seg", 32'(bus.segment), 32'hFF);
      chk("rst_valid", 32'(bus.bcd_valid), 32'd0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 33) chk("first_valid_early", 32'(bus.bcd_valid), 32'd0);
      if (k == 34) chk("first_valid", 32'(bus.bcd_valid), 32'd1);
      if (k == 35) begin
        chk("first_an", 32'(bus.AN), 32'hE);
        chk("first_seg", 32'(bus.segment), 32'hC0);
      end
    end

    for (int t = 0; t < 9; t++) begin
      bus.score   = tbl[t].score;
      bus.dp_mask = tbl[t].dp;
      ticks(40);
      chk_scan($sformatf("tbl%0d", t), tbl[t].seg, tbl[t].ovf);
    end

    // Overflow flag latency in both directions
    bus.dp_mask = '0;
    bus.score   = 32'd9999;
    ticks(40);
    bus.score = 32'd10000;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 33) chk("ovf_rise_early", 32'(bus.overflow), 32'd0);
      if (k == 34) chk("ovf_rise", 32'(bus.overflow), 32'd1);
    end
    bus.score = 32'd9999;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      if (k == 33) chk("ovf_fall_early", 32'(bus.overflow), 32'd1);
      if (k == 34) chk("ovf_fall", 32'(bus.overflow), 32'd0);
    end

    // Score change during SHIFT is deferred to the following conversion
    e5  = model_all(32'd5, 4'b0000);
    e42 = model_all(32'd42, 4'b0000);
    bus.score = 32'd5;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (k == 11) bus.score = 32'd42;
      if (k >= 35 && k <= 68) chk_lit("mid_5", e5, idx);
      if (k >= 69) chk_lit("mid_42", e42, idx);
    end

    // Randomized scores against the decimal reference
    cur_val = 32'd42;
    cur_dp  = 4'b0000;
    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 3))
        0:       cur_val = 32'($urandom_range(0, 9));
        1:       cur_val = 32'($urandom_range(0, 9999));
        2:       cur_val = 32'($urandom_range(10000, 99999));
        default: cur_val = $urandom;
      endcase
      cur_dp      = 4'($urandom_range(0, 15));
      bus.score   = cur_val;
      bus.dp_mask = cur_dp;
      ticks(40);
      chk_scan($sformatf("rnd%0d_%0d", r, cur_val), model_all(cur_val, cur_dp), cur_val >= 32'd10000);
    end

    // Blink: 10 cycles lit, 10 dark, scan keeps running
    ecur = model_all(cur_val, cur_dp);
    bus.blink_en = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (((k - 1) / 10) % 2 == 1) chk($sformatf("blink_off%0d", k), 32'(bus.AN), 32'hF);
      else chk_lit($sformatf("blink_on%0d", k), ecur, idx);
    end
    bus.blink_en = 1'b0;
    ticks(2);
    chk_lit("blink_clear", ecur, idx);

    // Reset in the middle of a conversion
    bus.score = 32'd123456;
    ticks(40);
    chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
    bus.score   = 32'd777;
    bus.dp_mask = 4'b0000;
    ticks(6);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", 32'(bus.AN), 32'hF);
    chk("midrst_seg", 32'(bus.segment), 32'hFF);
    chk("midrst_valid", 32'(bus.bcd_valid), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (k == 33) chk("post_rst_valid_early", 32'(bus.bcd_valid), 32'd0);
      if (k == 34) chk("post_rst_valid", 32'(bus.bcd_valid), 32'd1);
    end
    chk_scan("post_rst_777", model_all(32'd777, 4'b0000), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Parametrised successor to the 4-digit score display driver.
- Converts a binary score to BCD with a sequential double-dabble engine and time-multiplexes NUM_DIGITS seven-segment digits.
- Adds leading-zero blanking, per-digit decimal points, saturating overflow and a blink mode for game-over and start screens.
- Sits between the game loop's score output and the board segment/AN pins, clocked from clk_100mhz.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; range 1..8.
- SCORE_W, 32: width of the binary score input.
- CLK_HZ, 100000000: input clock frequency.
- SCAN_HZ, 1000: digit-advance rate, one digit step per 1/SCAN_HZ s.
- BLINK_HZ, 2: blink toggle rate; the off-phase lasts 1/(2*BLINK_HZ) s.
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock (clk_100mhz at top level).
- rst  in  1  synchronous, active-high reset.
- score  in  SCORE_W  unsigned binary score.
- blink_en  in  1  1 selects blinking display.
- dp_mask  in  NUM_DIGITS  1 lights the decimal point of digit i (digit 0 = least significant).
- segment  out  8  active-low: [7]=dp, [6:0]=g,f,e,d,c,b,a.
- AN  out  NUM_DIGITS  active-low digit enables.
- bcd_valid  out  1  high once the first conversion has completed.
- overflow  out  1  high when the displayed score is saturated.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - AN = all ones; segment = 8'hFF.
  - bcd_valid = 0; overflow = 0.
  - Display BCD registers = 0; FSM = IDLE.
  - Scan counter, digit index, blink counter = 0; last_score = 0.
  - Reset mid-conversion aborts the conversion; no partial result reaches the display registers.
- Conversion FSM: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE: if score != last_score, or bcd_valid == 0, capture score into the shift register and last_score. Clear the work BCD and the ovf flag. Go to SHIFT.
  - SHIFT: runs exactly SCORE_W cycles, MSB first. Each cycle:
    - add 3 to every work digit >= 5;
    - then shift {work BCD, shift reg} left by 1.
    - Any 1 shifted out of the top digit sets ovf (sticky).
  - DONE: one cycle. If ovf, load all digits = 9 and set overflow = 1. Otherwise load the work BCD and set overflow = 0. Set bcd_valid = 1. Go to IDLE.
  - Latency from score change to updated display registers: SCORE_W + 2 cycles.
  - Display registers update atomically in DONE only.
  - Score changes during SHIFT are ignored. IDLE compares against last_score on the cycle after DONE, so the final value is always converted.
- Scanner:
  - Prescaler counts 0..CLK_HZ/SCAN_HZ-1.
  - On terminal count, digit index increments and wraps NUM_DIGITS-1 -> 0.
  - Outputs are registered and change together on the clock after the index changes. Exactly one AN bit is low (AN[idx]=0) when displaying.
- Blanking, evaluated per scanned digit:
  - Digit i is blank (segment[6:0]=7'h7F) when BLANK_LZ=1, i != 0, and digits i..NUM_DIGITS-1 are all 0. Digit 0 always shows.
  - In overflow, no digit is blank.
  - dp still follows dp_mask[i] on blanked digits.
  - Before bcd_valid, all AN bits are high.
- Blink:
  - Counter toggles a phase bit every CLK_HZ/(2*BLINK_HZ) cycles while blink_en = 1.
  - Phase 1 forces AN to all ones; the scan continues running.
  - blink_en = 0 clears the phase to 0 (display on) on the next cycle.
- Segment encode, digit 0..9 to {g..a} active-low: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10. Codes above 9 cannot occur; if they do, show blank.
- Widths:
  - Work BCD is 4*NUM_DIGITS bits.
  - Prescaler and blink counters are sized by $clog2 of their terminal counts, minimum 1 bit.

Test Plan (bench uses CLK_HZ=1000, SCAN_HZ=250, BLINK_HZ=50, i.e. scan step 4 cycles, blink half-period 10 cycles):
- Reset:
  - Stimulus: hold rst 3 cycles with score=0.
  - Required: AN=4'hF, segment=8'hFF, bcd_valid=0 throughout.
  - After release: bcd_valid=1 at cycle 34; digit 0 then shows 8'hC0 with AN=4'hE.
- Conversion:
  - Stimulus: score=1234.
  - Required: after 34 cycles, the scan shows digit0 4 (8'h99), digit1 3 (8'hB0), digit2 2 (8'hA4), digit3 1 (8'hF9); AN sequence E,D,B,7 with 4 cycles per digit.
- Blanking:
  - Stimulus: score=7, dp_mask=4'b0100.
  - Required: digit0 = 8'hF8; digit1 = 8'hFF; digit2 = 8'h7F (blank with dp); digit3 = 8'hFF.
- Overflow:
  - Stimulus: score=10000.
  - Required: all digits = 8'h90, overflow=1.
  - Then score=9999: overflow=0 and the display is unchanged.
- Mid-conversion change:
  - Stimulus: score=5, then score=42 at cycle 10 of SHIFT.
  - Required: the display shows 5 first; 42 follows SCORE_W+2 cycles after that DONE; no intermediate value appears.
- Blink and reset mid-operation:
  - Stimulus: blink_en=1.
  - Required: AN alternates 10 cycles scanning / 10 cycles 4'hF.
  - Then assert rst during SHIFT: all outputs return to reset values the next cycle.
